dmem_access_ctrl: RTL and testbench

Sequences load/store requests from the core LSU onto the word-wide 1R1W data memory. The memory indexes words by byte address and only supports full-word writes.
- Byte and halfword stores are done as read-modify-write.
- Loads are lane-extracted and sign/zero-extended.
- Misaligned accesses are rejected with an error response.
Sits between the LSU and the data memory instance.

---
 rtl/dmem_ctrl_pkg.sv | 15 +
 rtl/dmem_lane_unit.sv | 51 +++++
 rtl/dmem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: access sizes and FSM states.
package dmem_ctrl_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: sub-word store merge, load lane extract with sign/zero extension,
// and alignment check. Zero latency, no flow control.
module dmem_lane_unit
   import dmem_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] old_word_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [1:0]      size_i,
   input  logic [1:0]      addr_lo_i,
   input  logic            unsigned_i,
   output logic [XLEN-1:0] merged_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            misalign_o
);

   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign byte_sh = {addr_lo_i, 3'b000};
   assign half_sh = {addr_lo_i[1], 4'b0000};
   assign lane_b  = old_word_i[byte_sh +: 8];
   assign lane_h  = old_word_i[half_sh +: 16];

   always_comb begin
      merged_o   = old_word_i;
      rdata_o    = '0;
      misalign_o = 1'b0;
      case (size_i)
         SZ_B: begin
            merged_o[byte_sh +: 8] = wdata_i[7:0];
            rdata_o = {{(XLEN-8){lane_b[7] & ~unsigned_i}}, lane_b};
         end
         SZ_H: begin
            misalign_o = addr_lo_i[0];
            merged_o[half_sh +: 16] = wdata_i[15:0];
            rdata_o = {{(XLEN-16){lane_h[15] & ~unsigned_i}}, lane_h};
         end
         SZ_W: begin
            misalign_o = |addr_lo_i;
            merged_o   = wdata_i;
            rdata_o    = old_word_i;
         end
         default: misalign_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// LSU-to-1R1W data memory sequencer: loads/word stores respond 2 cycles after the request cycle,
// sub-word stores (read-modify-write) 3; one request in flight, response held until rsp_ready.
module dmem_access_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32,
   localparam int ADDR_W = $clog2(DEPTH) + 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [XLEN-1:0]   mem_wr_din,
   output logic              mem_we,
   input  logic [XLEN-1:0]   mem_rd_dout
);

   state_t            state_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic [XLEN-1:0]   rsp_rdata_q;
   logic              we_q;
   logic              uns_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   merged_q;

   logic [XLEN-1:0]   merged_d;
   logic [XLEN-1:0]   ld_data;
   logic              misalign;
   logic              unused_addr_hi;

   // Upper address bits alias onto the small memory by design.
   assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_W];

   dmem_lane_unit #(.XLEN(XLEN)) u_lane (
      .old_word_i (mem_rd_dout),
      .wdata_i    (wdata_q),
      .size_i     (size_q),
      .addr_lo_i  (addr_q[1:0]),
      .unsigned_i (uns_q),
      .merged_o   (merged_d),
      .rdata_o    (ld_data),
      .misalign_o (misalign)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         size_q      <= 2'b00;
         addr_q      <= '0;
         wdata_q     <= '0;
         merged_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q        <= req_we;
                  size_q      <= req_size;
                  uns_q       <= req_unsigned;
                  addr_q      <= req_addr[ADDR_W-1:0];
                  wdata_q     <= req_wdata;
                  req_ready_q <= 1'b0;
                  state_q     <= EXEC;
               end
            end
            EXEC: begin
               rsp_rdata_q <= '0;
               rsp_err_q   <= misalign;
               if (misalign || !we_q || size_q == SZ_W) begin
                  if (!misalign && !we_q) begin
                     rsp_rdata_q <= ld_data;
                  end
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  merged_q <= merged_d;
                  state_q  <= WRITE;
               end
            end
            WRITE: begin
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Write enable comes straight from state so an async reset kills a pending write.
   assign mem_we = (state_q == WRITE) ||
                   (state_q == EXEC && we_q && size_q == SZ_W && !misalign);

   assign mem_rd_addr = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wr_addr = mem_rd_addr;
   assign mem_wr_din  = (state_q == WRITE) ? merged_q : wdata_q;

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural 1R1W memory and an in-order response scoreboard.
module tb_dmem_access_ctrl;

   localparam int DEPTH  = 4;
   localparam int XLEN   = 32;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [1:0]        req_size = 2'b00;
   logic              req_unsigned = 1'b0;
   logic [XLEN-1:0]   req_addr = '0;
   logic [XLEN-1:0]   req_wdata = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [XLEN-1:0]   rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [XLEN-1:0]   mem_wr_din;
   logic              mem_we;
   logic [XLEN-1:0]   mem_rd_dout;

   always #5 clk = ~clk;

   dmem_access_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_rd_addr  (mem_rd_addr),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_din   (mem_wr_din),
      .mem_we       (mem_we),
      .mem_rd_dout  (mem_rd_dout)
   );

   // Memory model: combinational read, write on rising edge, cleared by reset.
   logic [XLEN-1:0] mem [DEPTH];
   assign mem_rd_dout = mem[mem_rd_addr[ADDR_W-1:2]];
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (mem_we) begin
         mem[mem_wr_addr[ADDR_W-1:2]] <= mem_wr_din;
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      string       name;
   } exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   int   acc_cyc = 0;
   int   we_cnt  = 0;
   logic prev_vld = 1'b0;

   // Monitor: records accept cycle, counts write pulses, checks each new response against the queue.
   always @(negedge clk) begin
      if (mem_we) we_cnt++;
      if (req_valid && req_ready) acc_cyc = cyc;
      if (rsp_valid && !prev_vld) begin
         if (sbq.size() == 0) begin
            chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            chk({mon_e.name, "_rdata"}, rsp_rdata, mon_e.rdata);
            chk({mon_e.name, "_err"}, {31'b0, rsp_err}, {31'b0, mon_e.err});
            chk({mon_e.name, "_lat"}, 32'(cyc - acc_cyc), 32'(mon_e.lat));
         end
      end
      prev_vld = rsp_valid;
   end

   // Caller must be #1 after a rising edge; returns #1 after the accepting edge.
   task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input int elat,
                       input string nm, input bit push);
      int   n;
      exp_t x;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      if (push) begin
         x.rdata = erd;
         x.err   = eerr;
         x.lat   = elat;
         x.name  = nm;
         sbq.push_back(x);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while ((sbq.size() != 0 || rsp_valid) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (sbq.size() != 0 || rsp_valid) chk({nm, "_done_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input int elat, input string nm);
      send(we, sz, uns, addr, wd, erd, eerr, elat, nm, 1'b1);
      wait_done(nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   w0;
      int   hs_cyc;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
      chk("rst_mem_we",    {31'b0, mem_we}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // 1: word store then load back
      w0 = we_cnt;
      xact(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, 32'h0, 1'b0, 2, "t1_sw");
      chk("t1_sw_we_pulses", 32'(we_cnt - w0), 32'd1);
      xact(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hDEADBEEF, 1'b0, 2, "t1_lw");

      // 2: byte read-modify-write
      xact(1'b1, 2'b10, 1'b0, 32'h8, 32'h11223344, 32'h0, 1'b0, 2, "t2_sw");
      w0 = we_cnt;
      xact(1'b1, 2'b00, 1'b0, 32'h9, 32'h123456AA, 32'h0, 1'b0, 3, "t2_sb");
      chk("t2_sb_we_pulses", 32'(we_cnt - w0), 32'd1);
      xact(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h1122AA44, 1'b0, 2, "t2_lw");

      // 3: lane extraction, extension, halfword merge, aliasing
      xact(1'b1, 2'b10, 1'b0, 32'hC, 32'h80FF7F01, 32'h0, 1'b0, 2, "t3_sw");
      xact(1'b0, 2'b00, 1'b0, 32'hE, 32'h0, 32'hFFFFFFFF, 1'b0, 2, "t3_lb");
      xact(1'b0, 2'b00, 1'b1, 32'hE, 32'h0, 32'h000000FF, 1'b0, 2, "t3_lbu");
      xact(1'b0, 2'b01, 1'b0, 32'hE, 32'h0, 32'hFFFF80FF, 1'b0, 2, "t3_lh");
      xact(1'b0, 2'b01, 1'b1, 32'hC, 32'h0, 32'h00007F01, 1'b0, 2, "t3_lhu");
      xact(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, 32'h80FF7F01, 1'b0, 2, "t3_lw_alias");
      xact(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234CAFE, 32'h0, 1'b0, 3, "t3_sh");
      xact(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hCAFEBEEF, 1'b0, 2, "t3_lw_sh");

      // 4: misaligned and illegal accesses
      w0 = we_cnt;
      xact(1'b1, 2'b01, 1'b0, 32'h3, 32'hFFFFFFFF, 32'h0, 1'b1, 2, "t4_sh_mis");
      xact(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 2, "t4_lw_mis");
      xact(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 2, "t4_sz11");
      chk("t4_we_pulses", 32'(we_cnt - w0), 32'd0);
      xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2, "t4_lw0");
      xact(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h1122AA44, 1'b0, 2, "t4_lw8");

      // 5: response backpressure with a queued request
      rsp_ready = 1'b0;
      send(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h1122AA44, 1'b0, 2, "t5_lw", 1'b1);
      req_valid    = 1'b1;
      req_we       = 1'b0;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = 32'hC;
      req_wdata    = 32'h0;
      sbq.push_back('{32'h80FF7F01, 1'b0, 2, "t5_next"});
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_hold_valid", {31'b0, rsp_valid}, 32'd1);
         chk("t5_hold_rdata", rsp_rdata, 32'h1122AA44);
         chk("t5_hold_ready", {31'b0, req_ready}, 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      hs_cyc = cyc;
      @(posedge clk);
      @(posedge clk); #1;
      chk("t5_next_accept_cyc", 32'(acc_cyc), 32'(hs_cyc + 1));
      chk("t5_ready_after_acc", {31'b0, req_ready}, 32'd0);
      req_valid = 1'b0;
      wait_done("t5_next");

      // 6: reset during the write phase of a byte store
      send(1'b1, 2'b00, 1'b0, 32'h0, 32'h55, 32'h0, 1'b0, 3, "t6_sb", 1'b0);
      @(posedge clk); #1;
      chk("t6_we_in_write", {31'b0, mem_we}, 32'd1);
      rst = 1'b0;
      #1;
      chk("t6_we_async_drop", {31'b0, mem_we}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("t6_no_rsp_in_rst", {31'b0, rsp_valid}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t6_ready_after_rst", {31'b0, req_ready}, 32'd1);
      chk("t6_no_rsp_after_rst", {31'b0, rsp_valid}, 32'd0);
      chk("t6_sb_queue_empty", 32'(sbq.size()), 32'd0);
      xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2, "t6_lw0");

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
